// File: rtl/arb_pkg.sv
// Shared types for the physical-memory arbiter.
// FSM states and latched operation kind.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester after ptr,
// or lowest index when rotation is disabled.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 rr_en,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);

    int idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = rr_en ? (int'(ptr) + 1 + k) % N : k;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel cache-to-pmem arbiter with latched requests.
// Round-robin or fixed-priority grant; all outputs registered.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_addr,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int IW = $clog2(NUM_CH);

    arb_state_t        state_q, state_d;
    arb_op_t           op_q, op_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              read_d, write_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] wdata_d, rdata_d;
    logic [NUM_CH-1:0] resp_d;
    logic [NUM_CH-1:0] req;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;

    assign req = ch_read | ch_write;

    rr_pick #(
        .N(NUM_CH)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .rr_en    (RR_MODE != 0),
        .gnt_idx  (pick_idx),
        .gnt_valid(pick_valid)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        read_d  = pmem_read;
        write_d = pmem_write;
        addr_d  = pmem_addr;
        wdata_d = pmem_wdata;
        rdata_d = ch_rdata;
        resp_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // a simultaneous read+write is served as a write
                    grant_d = pick_idx;
                    op_d    = ch_write[pick_idx] ? OP_WRITE : OP_READ;
                    read_d  = ~ch_write[pick_idx];
                    write_d = ch_write[pick_idx];
                    addr_d  = ch_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[pick_idx*LINE_W +: LINE_W];
                    if (RR_MODE != 0) begin
                        ptr_d = pick_idx;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (op_q == OP_READ) begin
                        rdata_d = pmem_rdata;
                    end
                    resp_d  = NUM_CH'(1) << grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            grant_q    <= '0;
            ptr_q      <= IW'(NUM_CH - 1);
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            ch_rdata   <= '0;
            ch_resp    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pmem_read  <= read_d;
            pmem_write <= write_d;
            pmem_addr  <= addr_d;
            pmem_wdata <= wdata_d;
            ch_rdata   <= rdata_d;
            ch_resp    <= resp_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: round-robin and fixed-priority
// instances driven from shared inputs, transaction-level model.
module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int LW = 256;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_read, ch_write;
    logic [N*AW-1:0] ch_addr;
    logic [N*LW-1:0] ch_wdata;
    logic [LW-1:0]   pmem_rdata;
    logic            pmem_resp;

    logic [N-1:0]  rr_resp, fp_resp;
    logic [LW-1:0] rr_rdata, fp_rdata;
    logic          rr_pread, fp_pread, rr_pwrite, fp_pwrite;
    logic [AW-1:0] rr_paddr, fp_paddr;
    logic [LW-1:0] rr_pwdata, fp_pwdata;

    logic          sel_fp;
    logic [N-1:0]  o_resp;
    logic [LW-1:0] o_rdata, o_pwdata;
    logic          o_pread, o_pwrite;
    logic [AW-1:0] o_paddr;

    int n_cmp = 0;
    int n_bad = 0;
    int last_ptr;
    logic [LW-1:0] exp_rdata;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)
    ) dut_rr (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_resp(rr_resp), .ch_rdata(rr_rdata),
        .pmem_read(rr_pread), .pmem_write(rr_pwrite),
        .pmem_addr(rr_paddr), .pmem_wdata(rr_pwdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    mem_arbiter_rr #(
        .NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)
    ) dut_fp (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_resp(fp_resp), .ch_rdata(fp_rdata),
        .pmem_read(fp_pread), .pmem_write(fp_pwrite),
        .pmem_addr(fp_paddr), .pmem_wdata(fp_pwdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    assign o_resp   = sel_fp ? fp_resp   : rr_resp;
    assign o_rdata  = sel_fp ? fp_rdata  : rr_rdata;
    assign o_pread  = sel_fp ? fp_pread  : rr_pread;
    assign o_pwrite = sel_fp ? fp_pwrite : rr_pwrite;
    assign o_paddr  = sel_fp ? fp_paddr  : rr_paddr;
    assign o_pwdata = sel_fp ? fp_pwdata : rr_pwdata;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule: rotate from the last grant, or lowest index.
    function automatic int pick(input logic [N-1:0] req,
                                input int last, input bit rr);
        int c;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            c = rr ? (last + 1 + k) % N : k;
            if (pick < 0 && req[c]) pick = c;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ch_read    = '0;
        ch_write   = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        last_ptr  = N - 1;
        exp_rdata = '0;
    endtask

    // One full transaction: grant, hold for lat cycles, respond, retire.
    task automatic txn(input bit fp, input int lat, input bit mess,
                       output logic [N-1:0] got_resp);
        int w;
        bit is_wr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd, rv;
        logic [AW+1:0] hold;
        w     = pick(ch_read | ch_write, last_ptr, !fp);
        is_wr = ch_write[w];
        ea    = ch_addr[w*AW +: AW];
        ewd   = ch_wdata[w*LW +: LW];
        tick();
        n_cmp++;
        if (o_pread !== !is_wr) begin
            n_bad++;
            $display("FAIL grant_pread got %b exp %b", o_pread, !is_wr);
        end
        n_cmp++;
        if (o_pwrite !== is_wr) begin
            n_bad++;
            $display("FAIL grant_pwrite got %b exp %b", o_pwrite, is_wr);
        end
        n_cmp++;
        if (o_paddr !== ea) begin
            n_bad++;
            $display("FAIL grant_addr got %h exp %h", o_paddr, ea);
        end
        n_cmp++;
        if (o_pwdata !== ewd) begin
            n_bad++;
            $display("FAIL grant_wdata got %h exp %h", o_pwdata, ewd);
        end
        n_cmp++;
        if (o_resp !== '0) begin
            n_bad++;
            $display("FAIL busy_resp got %b exp 0", o_resp);
        end
        if (!fp) last_ptr = w;
        for (int c = 1; c < lat; c++) begin
            if (mess) begin
                ch_read[w]            = 1'($urandom);
                ch_write[w]           = 1'($urandom);
                ch_addr[w*AW +: AW]   = $urandom;
                ch_wdata[w*LW +: LW]  = rand_line();
            end
            tick();
            hold = {o_pread, o_pwrite, o_paddr};
            n_cmp++;
            if (hold !== {!is_wr, is_wr, ea} || o_resp !== '0) begin
                n_bad++;
                $display("FAIL busy_hold got %h/%b exp %h/0",
                         hold, o_resp, {!is_wr, is_wr, ea});
            end
        end
        rv         = rand_line();
        pmem_rdata = rv;
        pmem_resp  = 1'b1;
        tick();
        if (!is_wr) exp_rdata = rv;
        got_resp = o_resp;
        n_cmp++;
        if (o_resp !== N'(1) << w) begin
            n_bad++;
            $display("FAIL done_resp got %b exp %b", o_resp, N'(1) << w);
        end
        n_cmp++;
        if (o_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL done_rdata got %h exp %h", o_rdata, exp_rdata);
        end
        n_cmp++;
        if ({o_pread, o_pwrite} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_pmem got %b%b exp 00", o_pread, o_pwrite);
        end
        ch_read[w]  = 1'b0;
        ch_write[w] = 1'b0;
        pmem_resp   = 1'($urandom);
        pmem_rdata  = rand_line();
        tick();
        pmem_resp = 1'b0;
        n_cmp++;
        if (o_resp !== '0 || {o_pread, o_pwrite} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_quiet got %b/%b%b exp 0/00",
                     o_resp, o_pread, o_pwrite);
        end
        n_cmp++;
        if (o_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL idle_rdata got %h exp %h", o_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        sel_fp = 1'b0;
        do_reset();
        n_cmp++;
        if ({rr_resp, rr_pread, rr_pwrite} !== '0
            || rr_paddr !== '0 || rr_pwdata !== '0 || rr_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b%b%b %h exp zeros",
                     rr_resp, rr_pread, rr_pwrite, rr_paddr);
        end
    endtask

    task automatic test_single_read();
        logic [N-1:0] g;
        sel_fp = 1'b0;
        do_reset();
        ch_read[0]      = 1'b1;
        ch_addr[0 +: AW] = 32'h0000_1000;
        txn(1'b0, 5, 1'b0, g);
    endtask

    task automatic test_write_path();
        logic [N-1:0] g;
        sel_fp = 1'b0;
        do_reset();
        ch_read[2]           = 1'b1;
        ch_addr[2*AW +: AW]  = 32'h0000_2000;
        txn(1'b0, 2, 1'b0, g);
        ch_write[1]          = 1'b1;
        ch_addr[1*AW +: AW]  = 32'h0000_0040;
        ch_wdata[1*LW +: LW] = '1;
        txn(1'b0, 3, 1'b0, g);
        n_cmp++;
        if (g !== 4'b0010) begin
            n_bad++;
            $display("FAIL write_chan got %b exp 0010", g);
        end
    endtask

    task automatic test_rw_conflict();
        logic [N-1:0] g;
        sel_fp = 1'b0;
        do_reset();
        ch_read[0]  = 1'b1;
        ch_write[0] = 1'b1;
        ch_addr[0 +: AW]  = 32'h0000_0080;
        ch_wdata[0 +: LW] = rand_line();
        txn(1'b0, 2, 1'b0, g);
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] g;
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        sel_fp = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) ch_addr[i*AW +: AW] = 32'h100 * (i + 1);
        ch_read = '1;
        for (int t = 0; t < 6; t++) begin
            txn(1'b0, 1 + t % 3, 1'b0, g);
            n_cmp++;
            if (g !== N'(1) << seq[t]) begin
                n_bad++;
                $display("FAIL rr_order[%0d] got %b exp %b",
                         t, g, N'(1) << seq[t]);
            end
            ch_read = '1;
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] g;
        sel_fp = 1'b1;
        do_reset();
        ch_addr[1*AW +: AW] = 32'h0000_0111;
        ch_addr[3*AW +: AW] = 32'h0000_0333;
        ch_read = 4'b1010;
        txn(1'b1, 2, 1'b0, g);
        n_cmp++;
        if (g !== 4'b0010) begin
            n_bad++;
            $display("FAIL fp_first got %b exp 0010", g);
        end
        ch_read[1] = 1'b1;
        txn(1'b1, 1, 1'b0, g);
        n_cmp++;
        if (g !== 4'b0010) begin
            n_bad++;
            $display("FAIL fp_again got %b exp 0010", g);
        end
        txn(1'b1, 3, 1'b0, g);
        n_cmp++;
        if (g !== 4'b1000) begin
            n_bad++;
            $display("FAIL fp_after_drop got %b exp 1000", g);
        end
        sel_fp = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [N-1:0] g;
        sel_fp = 1'b0;
        do_reset();
        ch_read[0] = 1'b1;
        txn(1'b0, 2, 1'b0, g);
        ch_read[1]          = 1'b1;
        ch_addr[1*AW +: AW] = 32'h0000_5000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        ch_read = '0;
        n_cmp++;
        if ({rr_pread, rr_pwrite} !== 2'b00 || rr_resp !== '0) begin
            n_bad++;
            $display("FAIL rst_busy got %b%b/%b exp 00/0",
                     rr_pread, rr_pwrite, rr_resp);
        end
        last_ptr  = N - 1;
        exp_rdata = '0;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        n_cmp++;
        if ({rr_pread, rr_pwrite} !== 2'b00 || rr_resp !== '0) begin
            n_bad++;
            $display("FAIL idle_stray_resp got %b%b/%b exp 00/0",
                     rr_pread, rr_pwrite, rr_resp);
        end
        for (int i = 0; i < N; i++) ch_addr[i*AW +: AW] = 32'h900 + i;
        ch_read = '1;
        txn(1'b0, 2, 1'b0, g);
        n_cmp++;
        if (g !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_ptr got %b exp 0001", g);
        end
        ch_read = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        int op, f;
        sel_fp = 1'b0;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(ch_read[i] | ch_write[i]) && $urandom_range(1, 0) == 1) begin
                    op          = $urandom_range(2, 0);
                    ch_read[i]  = (op != 1);
                    ch_write[i] = (op != 0);
                    ch_addr[i*AW +: AW]  = $urandom;
                    ch_wdata[i*LW +: LW] = rand_line();
                end
            end
            if ((ch_read | ch_write) == '0) begin
                f = $urandom_range(N - 1, 0);
                ch_read[f] = 1'b1;
                ch_addr[f*AW +: AW] = $urandom;
            end
            txn(1'b0, $urandom_range(4, 1), 1'($urandom), g);
        end
    endtask

    initial begin
        sel_fp = 1'b0;
        test_reset();
        test_single_read();
        test_write_path();
        test_rw_conflict();
        test_rr_fairness();
        test_fixed_priority();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
